fifo_write_ctrl: RTL and testbench
==================================

Name: fifo_write_ctrl

Overview:
Write-side controller and status generator for the 4096-entry FIFO.
- Gates write requests and advances the write address.
- Tracks occupancy and drives fifo_full / fifo_empty; fifo_empty feeds the downstream read-address stage.
- Runs a 3-state status FSM, emits almost-full/almost-empty hints and overflow/underflow error pulses.

Parameters:
ADDR_W, 12, address width; write_address width.
DEPTH, 4096, entry count; must equal 2**ADDR_W.
AF_TH, 4032, almost_full asserts when count >= AF_TH.
AE_TH, 64, almost_empty asserts when count <= AE_TH.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
wr  input  1  raw write request from producer
rd  input  1  raw read request from consumer (same signal the read stage sees)
write_address  output  ADDR_W  current write address into FIFO memory
fifo_we  output  1  qualified write strobe = wr & ~fifo_full (combinational)
fifo_full  output  1  registered; count == DEPTH
fifo_empty  output  1  registered; count == 0
almost_full  output  1  registered; count >= AF_TH
almost_empty  output  1  registered; count <= AE_TH
fifo_count  output  ADDR_W+1  registered occupancy, 0..DEPTH
fifo_overflow  output  1  registered 1-cycle pulse: wr while full
fifo_underflow  output  1  registered 1-cycle pulse: rd while empty

Behaviour:
- Reset (rst==0 at a rising edge):
  - write_address=0, fifo_count=0, FSM=EMPTY.
  - fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, fifo_overflow=0, fifo_underflow=0.
  - fifo_we is combinational and therefore 0 while fifo_full=0 and wr=0.
- Reset mid-operation discards all occupancy; the next cycle behaves as an empty FIFO.
- Internal qualifiers:
  - we_ok = wr & ~fifo_full
  - rd_ok = rd & ~fifo_empty (identical to the read stage's fifo_rd)
- write_address increments by 1 on we_ok; wraps 4095 -> 0 (modulo 2**ADDR_W); otherwise holds.
- fifo_count next value:
  - +1 if we_ok & ~rd_ok
  - -1 if rd_ok & ~we_ok
  - unchanged if both or neither
- Simultaneous events:
  - When full, wr is blocked even if rd_ok in the same cycle; count becomes DEPTH-1.
  - When empty, rd is blocked even if we_ok in the same cycle; count becomes 1.
- Status FSM (EMPTY, PARTIAL, FULL) is evaluated on the next count:
  - EMPTY -> PARTIAL on we_ok.
  - PARTIAL -> EMPTY when next count == 0.
  - PARTIAL -> FULL when next count == DEPTH.
  - FULL -> PARTIAL on rd_ok.
  - No direct EMPTY <-> FULL transition.
- fifo_empty = (state==EMPTY); fifo_full = (state==FULL). Both registered; they update the cycle after the causing edge, with zero extra latency beyond the count register.
- almost_full/almost_empty are registered compares on the next count.
- fifo_overflow = registered (wr & fifo_full); fifo_underflow = registered (rd & fifo_empty). Each is 1-cycle, visible the cycle after the offending request.
- Invariant: fifo_count == write_address - read_address (mod DEPTH), except at full, where the difference is 0 and fifo_count == DEPTH.

Optional Feature:
Macro FIFO_ERR_STICKY_EN.
- Defined: fifo_overflow and fifo_underflow are sticky; once set they hold 1 until reset.
- Undefined: both are single-cycle pulses as above.
- All other behaviour is identical in both builds.

Decomposition:
Package fifo_pkg holds:
- ADDR_W, DEPTH, AF_TH/AE_TH defaults
- status-state enum (EMPTY=2'b00, PARTIAL=2'b01, FULL=2'b10)
- count width ADDR_W+1

One sub-module, write_address_pointer: wr, fifo_full, clk, rst in; write_address and fifo_we out; the write-side mirror of the read pointer stage. Count, FSM, flags and errors stay in fifo_write_ctrl.

Test Plan:
- Reset then idle 5 cycles -> fifo_empty=1, almost_empty=1, fifo_count=0, write_address=0, fifo_we=0.
- 4096 consecutive writes, no reads:
  - fifo_count=4096, fifo_full=1, write_address wraps to 0.
  - almost_full first high the cycle after the 4032nd write.
  - 4097th wr -> fifo_we=0, fifo_overflow=1 for exactly 1 cycle, count stays 4096.
- rd=1 on empty with wr=1 same cycle -> fifo_underflow pulse, count becomes 1, FSM EMPTY->PARTIAL, fifo_empty=0 next cycle.
- Full FIFO, wr=1 and rd=1 same cycle -> write blocked, count=4095, fifo_full=0 next cycle, write_address unchanged.
- Count=100, random wr/rd for 10k cycles -> count == writes_accepted - reads_accepted at every cycle; flags match count compares.
- rst=0 for one cycle at count=2000 -> all outputs at reset values next cycle.
- With FIFO_ERR_STICKY_EN defined, repeat the overflow case -> flag stays 1 until reset.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and status-state encoding for the 4096-entry FIFO write-side controller.
// The FIFO_ERR_STICKY_EN build option is handled in fifo_write_ctrl.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 12;
    localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;
    localparam int FIFO_AF_TH  = 4032;
    localparam int FIFO_AE_TH  = 64;
    localparam int FIFO_CNT_W  = FIFO_ADDR_W + 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        PARTIAL = 2'b01,
        FULL    = 2'b10
    } status_state_t;

endpackage

// File: rtl/write_address_pointer.sv
// Write-side pointer stage: qualifies raw writes against fifo_full and advances the write address.
module write_address_pointer #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              fifo_full,
    output logic [ADDR_W-1:0] write_address,
    output logic              fifo_we
);

    assign fifo_we = wr & ~fifo_full;

    // The address wraps naturally at 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_address <= '0;
        end else if (fifo_we) begin
            write_address <= write_address + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write controller and status generator: occupancy count, EMPTY/PARTIAL/FULL FSM, threshold hints, error flags.
// Define FIFO_ERR_STICKY_EN to make the overflow/underflow flags hold until reset.
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int AF_TH  = FIFO_AF_TH,
    parameter int AE_TH  = FIFO_AE_TH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    output logic [ADDR_W-1:0] write_address,
    output logic              fifo_we,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam int CNT_W = ADDR_W + 1;

    status_state_t    state, state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             we_ok, rd_ok;

    write_address_pointer #(
        .ADDR_W(ADDR_W)
    ) u_wptr (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .fifo_full    (fifo_full),
        .write_address(write_address),
        .fifo_we      (fifo_we)
    );

    assign we_ok = fifo_we;
    assign rd_ok = rd & ~fifo_empty;

    assign fifo_empty = (state == EMPTY);
    assign fifo_full  = (state == FULL);

    always_comb begin
        count_nxt = fifo_count;
        if (we_ok && !rd_ok) begin
            count_nxt = fifo_count + 1'b1;
        end else if (rd_ok && !we_ok) begin
            count_nxt = fifo_count - 1'b1;
        end
    end

    // EMPTY and FULL are only ever left through PARTIAL.
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (we_ok) state_nxt = PARTIAL;
            end
            PARTIAL: begin
                if (count_nxt == '0)                 state_nxt = EMPTY;
                else if (count_nxt == CNT_W'(DEPTH)) state_nxt = FULL;
            end
            FULL: begin
                if (rd_ok) state_nxt = PARTIAL;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= EMPTY;
            fifo_count     <= '0;
            almost_full    <= 1'b0;
            almost_empty   <= 1'b1;
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            state        <= state_nxt;
            fifo_count   <= count_nxt;
            almost_full  <= (count_nxt >= CNT_W'(AF_TH));
            almost_empty <= (count_nxt <= CNT_W'(AE_TH));
`ifdef FIFO_ERR_STICKY_EN
            fifo_overflow  <= fifo_overflow  | (wr & fifo_full);
            fifo_underflow <= fifo_underflow | (rd & fifo_empty);
`else
            fifo_overflow  <= wr & fifo_full;
            fifo_underflow <= rd & fifo_empty;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Self-checking bench for fifo_write_ctrl: vector table, corner-case sequences and a random run
// against an occupancy-level reference model.
module tb_fifo_write_ctrl;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;
    localparam int AF_TH  = 4032;
    localparam int AE_TH  = 64;
`ifdef FIFO_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] write_address;
    logic              fifo_we;
    logic              fifo_full;
    logic              fifo_empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_overflow;
    logic              fifo_underflow;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: plain occupancy, write index and error flags.
    int m_count = 0;
    int m_waddr = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    typedef struct {
        logic rst_v;
        logic wr_v;
        logic rd_v;
        int   exp_count;
        logic exp_empty;
        logic exp_full;
        logic exp_ovf;
        logic exp_unf;
    } vec_t;

    vec_t vecs[9];

    fifo_write_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .wr            (wr),
        .rd            (rd),
        .write_address (write_address),
        .fifo_we       (fifo_we),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .fifo_count    (fifo_count),
        .fifo_overflow (fifo_overflow),
        .fifo_underflow(fifo_underflow)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("fifo_count", int'(fifo_count), m_count);
        checkVal("write_address", int'(write_address), m_waddr);
        checkVal("fifo_empty", int'(fifo_empty), int'(m_count == 0));
        checkVal("fifo_full", int'(fifo_full), int'(m_count == DEPTH));
        checkVal("almost_full", int'(almost_full), int'(m_count >= AF_TH));
        checkVal("almost_empty", int'(almost_empty), int'(m_count <= AE_TH));
        checkVal("fifo_overflow", int'(fifo_overflow), int'(m_ovf));
        checkVal("fifo_underflow", int'(fifo_underflow), int'(m_unf));
    endtask

    // Drives one cycle, checks the combinational strobe before the edge and everything after it.
    task automatic applyStimulus(input logic rst_v, input logic wr_v, input logic rd_v);
        bit m_full, m_empty, we_ok, rd_ok;
        rst = rst_v;
        wr  = wr_v;
        rd  = rd_v;
        #1;
        m_full  = (m_count == DEPTH);
        m_empty = (m_count == 0);
        checkVal("fifo_we", int'(fifo_we), int'(wr_v && !m_full));
        @(posedge clk);
        #1;
        if (!rst_v) begin
            m_count = 0;
            m_waddr = 0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            we_ok   = wr_v && !m_full;
            rd_ok   = rd_v && !m_empty;
            m_count = m_count + int'(we_ok) - int'(rd_ok);
            m_waddr = (m_waddr + int'(we_ok)) % DEPTH;
            m_ovf   = (STICKY && m_ovf) || (wr_v && m_full);
            m_unf   = (STICKY && m_unf) || (rd_v && m_empty);
        end
        checkOutput();
    endtask

    initial begin
        rst = 1'b0;
        wr  = 1'b0;
        rd  = 1'b0;

        // Hand-derived short sequence from reset, including a write+read on an empty FIFO.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, STICKY};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, STICKY};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, STICKY};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, STICKY};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, STICKY};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].rst_v, vecs[i].wr_v, vecs[i].rd_v);
            checkVal($sformatf("vec%0d_count", i), int'(fifo_count), vecs[i].exp_count);
            checkVal($sformatf("vec%0d_empty", i), int'(fifo_empty), int'(vecs[i].exp_empty));
            checkVal($sformatf("vec%0d_full", i), int'(fifo_full), int'(vecs[i].exp_full));
            checkVal($sformatf("vec%0d_ovf", i), int'(fifo_overflow), int'(vecs[i].exp_ovf));
            checkVal($sformatf("vec%0d_unf", i), int'(fifo_underflow), int'(vecs[i].exp_unf));
        end

        // Idle after reset.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkVal("idle_empty", int'(fifo_empty), 1);
        checkVal("idle_almost_empty", int'(almost_empty), 1);
        checkVal("idle_count", int'(fifo_count), 0);
        checkVal("idle_waddr", int'(write_address), 0);
        checkVal("idle_we", int'(fifo_we), 0);

        // Fill completely; almost_full must rise exactly after the AF_TH-th write.
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            if (i == AF_TH - 1) checkVal("af_before_th", int'(almost_full), 0);
            if (i == AF_TH)     checkVal("af_at_th", int'(almost_full), 1);
        end
        checkVal("fill_count", int'(fifo_count), DEPTH);
        checkVal("fill_full", int'(fifo_full), 1);
        checkVal("fill_waddr_wrap", int'(write_address), 0);

        // Write into a full FIFO.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkVal("ovf_pulse", int'(fifo_overflow), 1);
        checkVal("ovf_count", int'(fifo_count), DEPTH);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkVal("ovf_after", int'(fifo_overflow), int'(STICKY));

        // Write and read together while full: write blocked, read accepted.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkVal("fullrw_count", int'(fifo_count), DEPTH - 1);
        checkVal("fullrw_full", int'(fifo_full), 0);
        checkVal("fullrw_waddr", int'(write_address), 0);

        // Random traffic starting from occupancy 100.
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkVal("rand_start_count", int'(fifo_count), 100);
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        // Reset in the middle of operation at occupancy 2000.
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkVal("pre_rst_count", int'(fifo_count), 2000);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkVal("rst_count", int'(fifo_count), 0);
        checkVal("rst_waddr", int'(write_address), 0);
        checkVal("rst_empty", int'(fifo_empty), 1);
        checkVal("rst_almost_empty", int'(almost_empty), 1);
        checkVal("rst_full", int'(fifo_full), 0);
        checkVal("rst_almost_full", int'(almost_full), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkVal("post_rst_count", int'(fifo_count), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
